ans_session_ctrl: RTL and testbench

//  Sequences one complete ANS decode session on the ans core: table load, then decode.

---
 rtl/ans_session_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ans_session_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ans_session_ctrl.sv
// Session sequencer for the ANS core: table load, then decode.
// Gates host nibble streams onto the core handshakes, counts beats and watches for stalls.
module ans_session_ctrl #(
    parameter int SYM_WIDTH    = 4,
    parameter int LOAD_NIBBLES = 16,
    parameter int LEN_WIDTH    = 8,
    parameter int TIMEOUT      = 255,
    parameter int TO_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] num_syms,
    input  logic [SYM_WIDTH-1:0] host_in,
    input  logic                 host_in_vld,
    output logic                 host_in_rdy,
    output logic [SYM_WIDTH-1:0] host_out,
    output logic                 host_out_vld,
    input  logic                 host_out_rdy,
    output logic [1:0]           core_cmd,
    output logic [SYM_WIDTH-1:0] core_in,
    output logic                 core_in_vld,
    input  logic                 core_in_rdy,
    input  logic [SYM_WIDTH-1:0] core_out,
    input  logic                 core_out_vld,
    output logic                 core_out_rdy,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int LC_W = (LOAD_NIBBLES > 1) ? $clog2(LOAD_NIBBLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SWITCH,
        S_DECODE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_DECODE = 2'b10;
    localparam logic [1:0] CMD_LOAD   = 2'b11;

    state_t               state_q, state_d;
    logic [LC_W-1:0]      load_cnt_q, load_cnt_d;
    logic [LEN_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
    logic [LEN_WIDTH-1:0] num_syms_q, num_syms_d;
    logic [TO_WIDTH-1:0]  wdog_q, wdog_d;
    logic [1:0]           cmd_q;
    logic                 done_q;
    logic                 err_q;

    logic in_hs;
    logic out_hs;
    logic wd_active;

    function automatic logic [1:0] cmd_of(input state_t s);
        case (s)
            S_LOAD:   return CMD_LOAD;
            S_DECODE: return CMD_DECODE;
            default:  return CMD_IDLE;
        endcase
    endfunction

    // State register; core_cmd/done/err are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            sym_cnt_q  <= '0;
            num_syms_q <= '0;
            wdog_q     <= '0;
            cmd_q      <= CMD_IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            num_syms_q <= num_syms_d;
            wdog_q     <= wdog_d;
            cmd_q      <= cmd_of(state_d);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

    // Next-state: abort beats watchdog expiry, which beats the normal transitions.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        num_syms_d = num_syms_q;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    num_syms_d = num_syms;
                    load_cnt_d = '0;
                    sym_cnt_d  = '0;
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    if (load_cnt_q == LC_W'(LOAD_NIBBLES - 1)) begin
                        state_d    = S_SWITCH;
                        load_cnt_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + LC_W'(1);
                    end
                end
            end
            S_SWITCH: begin
                state_d = (num_syms_q != '0) ? S_DECODE : S_DONE;
            end
            S_DECODE: begin
                if (out_hs) begin
                    if (sym_cnt_q == num_syms_q - LEN_WIDTH'(1)) begin
                        state_d   = S_DONE;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wd_active) begin
            if (in_hs || out_hs) begin
                wdog_d = '0;
            end else if (wdog_q == TO_WIDTH'(TIMEOUT - 1)) begin
                state_d = S_ERR;
            end else begin
                wdog_d = wdog_q + TO_WIDTH'(1);
            end
        end

        if (state_d != state_q) begin
            wdog_d = '0;
        end

        if (abort) begin
            state_d    = S_IDLE;
            load_cnt_d = '0;
            sym_cnt_d  = '0;
            wdog_d     = '0;
        end
    end

    // Handshake gating; the abort cycle still passes beats through to the core.
    always_comb begin
        host_in_rdy  = 1'b0;
        core_in_vld  = 1'b0;
        host_out_vld = 1'b0;
        core_out_rdy = 1'b0;
        host_out     = '0;
        if (state_q == S_LOAD || state_q == S_DECODE) begin
            core_in_vld = host_in_vld;
            host_in_rdy = core_in_rdy;
        end
        if (state_q == S_DECODE) begin
            host_out_vld = core_out_vld;
            core_out_rdy = host_out_rdy;
            host_out     = core_out;
        end
    end

    assign wd_active = (state_q == S_LOAD) || (state_q == S_DECODE);
    assign in_hs     = core_in_vld && core_in_rdy;
    assign out_hs    = host_out_vld && host_out_rdy;

    assign core_in  = host_in;
    assign core_cmd = cmd_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_SWITCH) || (state_q == S_DECODE);

endmodule

// File: tb/tb_ans_session_ctrl.sv
// Directed bench for ans_session_ctrl: stimulus pushes expected beats into queues,
// a negedge monitor pops and compares whenever a handshake completes.
module tb_ans_session_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] num_syms;
    logic [3:0] host_in;
    logic       host_in_vld, host_in_rdy;
    logic [3:0] host_out;
    logic       host_out_vld, host_out_rdy;
    logic [1:0] core_cmd;
    logic [3:0] core_in;
    logic       core_in_vld, core_in_rdy;
    logic [3:0] core_out;
    logic       core_out_vld, core_out_rdy;
    logic       busy, done, err;

    always #5 clk = ~clk;

    ans_session_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_syms    (num_syms),
        .host_in     (host_in),
        .host_in_vld (host_in_vld),
        .host_in_rdy (host_in_rdy),
        .host_out    (host_out),
        .host_out_vld(host_out_vld),
        .host_out_rdy(host_out_rdy),
        .core_cmd    (core_cmd),
        .core_in     (core_in),
        .core_in_vld (core_in_vld),
        .core_in_rdy (core_in_rdy),
        .core_out    (core_out),
        .core_out_vld(core_out_vld),
        .core_out_rdy(core_out_rdy),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int core_hs_cnt = 0;
    logic [3:0] exp_in_q[$];
    logic [3:0] exp_out_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed beat must match the next expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_in_vld && core_in_rdy) begin
                core_hs_cnt++;
                if (exp_in_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL core_in: got unexpected nibble %0h, expected none", core_in);
                end else begin
                    check("core_in", core_in, exp_in_q.pop_front());
                end
            end
            if (host_out_vld && host_out_rdy) begin
                if (exp_out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL host_out: got unexpected symbol %0h, expected none", host_out);
                end else begin
                    check("host_out", host_out, exp_out_q.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic begin_session(input logic [7:0] n);
        start    = 1'b1;
        num_syms = n;
        step();
        start = 1'b0;
        check("cmd after start", core_cmd, 2'b11);
    endtask

    // Feeds 16 table nibbles back to back; optionally pokes start mid-load.
    task automatic load_table(input logic [3:0] seed, input int poke_at);
        for (int i = 0; i < 16; i++) begin
            host_in     = seed + 4'(i);
            host_in_vld = 1'b1;
            if (i == poke_at) begin
                start    = 1'b1;
                num_syms = 8'd9;
            end else begin
                start = 1'b0;
            end
            exp_in_q.push_back(host_in);
            step();
        end
        start       = 1'b0;
        host_in_vld = 1'b0;
    endtask

    task automatic emit(input logic [3:0] s);
        core_out     = s;
        core_out_vld = 1'b1;
        host_out_rdy = 1'b1;
        exp_out_q.push_back(s);
        step();
        core_out_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        num_syms     = '0;
        host_in      = '0;
        host_in_vld  = 1'b0;
        host_out_rdy = 1'b1;
        core_in_rdy  = 1'b1;
        core_out     = '0;
        core_out_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state.
        check("reset cmd", core_cmd, 2'b00);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset host_in_rdy", host_in_rdy, 1'b0);
        check("reset host_out", host_out, 4'h0);

        // 1) Full session, 3 symbols; start during DONE is ignored.
        begin_session(8'd3);
        check("t1 busy", busy, 1'b1);
        load_table(4'h3, -1);
        check("t1 switch cmd", core_cmd, 2'b00);
        step();
        check("t1 decode cmd", core_cmd, 2'b10);
        emit(4'hA);
        emit(4'hB);
        emit(4'hC);
        check("t1 done", done, 1'b1);
        check("t1 done cmd", core_cmd, 2'b00);
        start    = 1'b1;
        num_syms = 8'd7;
        step();
        start = 1'b0;
        check("t1 start in DONE ignored", core_cmd, 2'b00);
        check("t1 idle busy", busy, 1'b0);
        check("t1 done cleared", done, 1'b0);
        check("t1 done count", done_cnt, 1);

        // 2) Toggling host_in_vld during LOAD; SWITCH lasts one cycle.
        begin_session(8'd1);
        hs0 = core_hs_cnt;
        for (int i = 0; i < 31; i++) begin
            host_in_vld = (i % 2 == 0);
            host_in     = 4'(i >> 1) ^ 4'hA;
            if (host_in_vld) exp_in_q.push_back(host_in);
            if (i == 7) check("t2 mid-load cmd", core_cmd, 2'b11);
            step();
        end
        host_in_vld = 1'b0;
        check("t2 core handshakes", core_hs_cnt - hs0, 16);
        check("t2 switch cmd", core_cmd, 2'b00);
        step();
        check("t2 switch one cycle", core_cmd, 2'b10);
        emit(4'h5);
        check("t2 done", done, 1'b1);
        step();

        // 3) num_syms = 0: LOAD, SWITCH, DONE with no decode and no output beat.
        begin_session(8'd0);
        load_table(4'h0, -1);
        host_in_vld  = 1'b1;
        core_out     = 4'h9;
        core_out_vld = 1'b1;
        settle();
        check("t3 switch core_in_vld", core_in_vld, 1'b0);
        check("t3 switch host_in_rdy", host_in_rdy, 1'b0);
        check("t3 switch host_out_vld", host_out_vld, 1'b0);
        check("t3 switch cmd", core_cmd, 2'b00);
        step();
        check("t3 done cmd", core_cmd, 2'b00);
        check("t3 done", done, 1'b1);
        check("t3 done host_out_vld", host_out_vld, 1'b0);
        check("t3 done core_out_rdy", core_out_rdy, 1'b0);
        host_in_vld  = 1'b0;
        core_out_vld = 1'b0;
        step();
        check("t3 idle cmd", core_cmd, 2'b00);
        check("t3 done count", done_cnt, 3);

        // 4) Output back-pressure for 10 cycles while the input stream keeps flowing.
        begin_session(8'd4);
        load_table(4'h7, -1);
        step();
        check("t4 decode cmd", core_cmd, 2'b10);
        emit(4'h1);
        core_out     = 4'h2;
        core_out_vld = 1'b1;
        host_out_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            host_in     = 4'(k);
            host_in_vld = 1'b1;
            exp_in_q.push_back(host_in);
            if (k == 4) begin
                settle();
                check("t4 stall core_out_rdy", core_out_rdy, 1'b0);
                check("t4 stall host_out_vld", host_out_vld, 1'b1);
                check("t4 stall host_out", host_out, 4'h2);
            end
            step();
        end
        host_in_vld = 1'b0;
        check("t4 stall no beat lost", exp_out_q.size(), 0);
        check("t4 stall still decoding", core_cmd, 2'b10);
        emit(4'h2);
        emit(4'h3);
        emit(4'h4);
        check("t4 done", done, 1'b1);
        step();
        check("t4 done count", done_cnt, 4);

        // 5) Silent host in LOAD trips the watchdog; start from ERR recovers.
        begin_session(8'd2);
        repeat (7) step();
        check("t5 still load cmd", core_cmd, 2'b11);
        check("t5 no err yet", err, 1'b0);
        step();
        check("t5 err", err, 1'b1);
        check("t5 err cmd", core_cmd, 2'b00);
        check("t5 err busy", busy, 1'b0);
        host_in_vld = 1'b1;
        settle();
        check("t5 err host_in_rdy", host_in_rdy, 1'b0);
        host_in_vld = 1'b0;
        step();
        check("t5 err sticky", err, 1'b1);
        begin_session(8'd1);
        check("t5 err cleared", err, 1'b0);
        host_in     = 4'hE;
        host_in_vld = 1'b1;
        abort       = 1'b1;
        exp_in_q.push_back(host_in);
        step();
        abort       = 1'b0;
        host_in_vld = 1'b0;
        check("t5 abort cmd", core_cmd, 2'b00);
        check("t5 abort busy", busy, 1'b0);

        // 6) start during LOAD ignored; abort in DECODE after 1 of 5 symbols.
        begin_session(8'd5);
        load_table(4'hC, 5);
        check("t6 switch on time", core_cmd, 2'b00);
        step();
        check("t6 decode cmd", core_cmd, 2'b10);
        emit(4'h6);
        core_out     = 4'h7;
        core_out_vld = 1'b1;
        host_out_rdy = 1'b1;
        abort        = 1'b1;
        exp_out_q.push_back(core_out);
        step();
        abort        = 1'b0;
        core_out_vld = 1'b0;
        check("t6 abort busy", busy, 1'b0);
        check("t6 abort cmd", core_cmd, 2'b00);
        check("t6 abort no done", done, 1'b0);
        step();
        check("t6 still no done", done, 1'b0);
        check("t6 done count", done_cnt, 4);

        // 7) Reset mid-session.
        begin_session(8'd2);
        step();
        rst_n = 1'b0;
        #1;
        check("t7 reset cmd", core_cmd, 2'b00);
        check("t7 reset busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("t7 idle after reset", core_cmd, 2'b00);

        check("input queue drained", exp_in_q.size(), 0);
        check("output queue drained", exp_out_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
